// File: rtl/sdram_arbit_if.sv
// Sub-block and SDRAM-pin bundle around sdram_arbit.
// slave = the arbiter's view; master = the sub-blocks/pins side.
interface sdram_arbit_if;
   logic        flag_init_end;
   logic [3:0]  init_cmd;
   logic [11:0] init_addr;
   logic        ref_req;
   logic        flag_ref_end;
   logic [3:0]  aref_cmd;
   logic [11:0] aref_addr;
   logic        wr_req;
   logic        flag_wr_end;
   logic [3:0]  wr_cmd;
   logic [11:0] wr_addr;
   logic [1:0]  wr_bank;
   logic        rd_req;
   logic        flag_rd_end;
   logic [3:0]  rd_cmd;
   logic [11:0] rd_addr;
   logic [1:0]  rd_bank;
   logic        ref_en;
   logic        wr_en;
   logic        rd_en;
   logic [3:0]  sdram_cmd;
   logic [11:0] sdram_addr;
   logic [1:0]  sdram_bank;
   logic        busy;

   modport slave (
      input  flag_init_end, init_cmd, init_addr,
      input  ref_req, flag_ref_end, aref_cmd, aref_addr,
      input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
      input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
      output ref_en, wr_en, rd_en,
      output sdram_cmd, sdram_addr, sdram_bank, busy
   );

   modport master (
      output flag_init_end, init_cmd, init_addr,
      output ref_req, flag_ref_end, aref_cmd, aref_addr,
      output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
      output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
      input  ref_en, wr_en, rd_en,
      input  sdram_cmd, sdram_addr, sdram_bank, busy
   );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command-bus scheduler: init, then refresh > write/read (round-robin),
// with one-cycle grant pulses and a configurable NOP gap between operations.
module sdram_arbit #(
   parameter int unsigned GAP_CYC = 1,
   parameter logic [3:0]  CMD_NOP = 4'b0111
) (
   input  logic         clk,
   input  logic         rst,
   sdram_arbit_if.slave bus
);

   localparam logic [3:0] GAP = 4'(GAP_CYC);

   typedef enum logic [2:0] {
      S_INIT,
      S_ARBIT,
      S_AREF,
      S_WRITE,
      S_READ
   } state_t;

   state_t     state, state_nxt;
   logic       ref_en_q, wr_en_q, rd_en_q;
   logic       ref_en_nxt, wr_en_nxt, rd_en_nxt;
   logic       last_rw, last_rw_nxt;
   logic [3:0] gap_cnt;
   logic       gap_done;

   assign gap_done = (gap_cnt == GAP);

   always_comb begin
      state_nxt   = state;
      ref_en_nxt  = 1'b0;
      wr_en_nxt   = 1'b0;
      rd_en_nxt   = 1'b0;
      last_rw_nxt = last_rw;
      case (state)
         S_INIT:
            if (bus.flag_init_end) state_nxt = S_ARBIT;
         S_ARBIT:
            if (gap_done) begin
               if (bus.ref_req) begin
                  state_nxt  = S_AREF;
                  ref_en_nxt = 1'b1;
               end else if (bus.wr_req && (!bus.rd_req || last_rw)) begin
                  // tie goes to the side opposite the last served one
                  state_nxt   = S_WRITE;
                  wr_en_nxt   = 1'b1;
                  last_rw_nxt = 1'b0;
               end else if (bus.rd_req) begin
                  state_nxt   = S_READ;
                  rd_en_nxt   = 1'b1;
                  last_rw_nxt = 1'b1;
               end
            end
         S_AREF:
            if (bus.flag_ref_end) state_nxt = S_ARBIT;
         S_WRITE:
            if (bus.flag_wr_end) state_nxt = S_ARBIT;
         S_READ:
            if (bus.flag_rd_end) state_nxt = S_ARBIT;
         default:
            state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_INIT;
         ref_en_q <= 1'b0;
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         last_rw  <= 1'b1;
      end else begin
         state    <= state_nxt;
         ref_en_q <= ref_en_nxt;
         wr_en_q  <= wr_en_nxt;
         rd_en_q  <= rd_en_nxt;
         last_rw  <= last_rw_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_cnt <= '0;
      end else if (state != S_ARBIT) begin
         gap_cnt <= '0;
      end else if (!gap_done) begin
         gap_cnt <= gap_cnt + 4'd1;
      end
   end

   always_comb begin
      bus.sdram_cmd  = CMD_NOP;
      bus.sdram_addr = '0;
      bus.sdram_bank = '0;
      case (state)
         S_INIT: begin
            bus.sdram_cmd  = bus.init_cmd;
            bus.sdram_addr = bus.init_addr;
         end
         S_AREF: begin
            bus.sdram_cmd  = bus.aref_cmd;
            bus.sdram_addr = bus.aref_addr;
         end
         S_WRITE: begin
            bus.sdram_cmd  = bus.wr_cmd;
            bus.sdram_addr = bus.wr_addr;
            bus.sdram_bank = bus.wr_bank;
         end
         S_READ: begin
            bus.sdram_cmd  = bus.rd_cmd;
            bus.sdram_addr = bus.rd_addr;
            bus.sdram_bank = bus.rd_bank;
         end
         default: ;
      endcase
   end

   assign bus.ref_en = ref_en_q;
   assign bus.wr_en  = wr_en_q;
   assign bus.rd_en  = rd_en_q;
   assign bus.busy   = (state != S_ARBIT);

endmodule
